// File: rtl/hazard_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// hazard_ctrl : forwarding, stall/flush and multi-cycle MD control, rev 1.0
// ------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REGW         = 5,
   parameter int MD_LAT       = 32,
   parameter int EARLY_BRANCH = 0,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REGW-1:0]  rsD,
   input  logic [REGW-1:0]  rtD,
   input  logic [REGW-1:0]  rsE,
   input  logic [REGW-1:0]  rtE,
   input  logic [REGW-1:0]  writeRegE,
   input  logic [REGW-1:0]  writeRegM,
   input  logic [REGW-1:0]  writeRegW,
   input  logic             regWriteE,
   input  logic             regWriteM,
   input  logic             regWriteW,
   input  logic             memToRegE,
   input  logic             memToRegM,
   input  logic             branchD,
   input  logic             jumpD,
   input  logic             PCSrcE,
   input  logic             PCSrcD,
   input  logic             mdStartE,
   input  logic             mdUseD,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic             mdBusy,
   output logic             mdDone,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam logic       EB        = (EARLY_BRANCH != 0);
   localparam logic [7:0] MD_RELOAD = 8'(MD_LAT - 1);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   md_state_t  md_state;
   logic [7:0] md_cnt;
   logic       busy_q;
   logic       done_q;

   logic       lw_stall;
   logic       br_stall;
   logic       md_stall;
   logic       stall_raw;
   logic       stall_fin;
   logic       rsd_hit_e;
   logic       rtd_hit_e;
   logic       rsd_hit_m;
   logic       rtd_hit_m;

   // Status is registered but forced low combinationally while reset is held.
   assign mdBusy = busy_q & ~reset;
   assign mdDone = done_q & ~reset;

   always_comb begin
      rsd_hit_e = (writeRegE != '0) && (writeRegE == rsD);
      rtd_hit_e = (writeRegE != '0) && (writeRegE == rtD);
      rsd_hit_m = (writeRegM != '0) && (writeRegM == rsD);
      rtd_hit_m = (writeRegM != '0) && (writeRegM == rtD);

      lw_stall  = memToRegE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
      br_stall  = EB && branchD &&
                  ((regWriteE && (rsd_hit_e || rtd_hit_e)) ||
                   (memToRegM && (rsd_hit_m || rtd_hit_m)));
      md_stall  = mdUseD && (mdBusy || mdStartE);
      stall_raw = lw_stall | br_stall | md_stall;

      // With late branches a taken branch squashes whatever was stalled.
      stall_fin = (!EB && PCSrcE) ? 1'b0 : stall_raw;

      stallF    = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b1;
      flushE    = 1'b1;
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      forwardAD = 1'b0;
      forwardBD = 1'b0;

      if (!reset) begin
         stallF = stall_fin;
         stallD = stall_fin;
         if (EB) begin
            flushD = (PCSrcD | jumpD) & ~stall_fin;
            flushE = stall_fin;
         end else begin
            flushD = PCSrcE | (jumpD & ~stall_fin);
            flushE = PCSrcE | stall_raw;
         end

         if ((rsE != '0) && regWriteM && (writeRegM == rsE))
            forwardAE = 2'b10;
         else if ((rsE != '0) && regWriteW && (writeRegW == rsE))
            forwardAE = 2'b01;

         if ((rtE != '0) && regWriteM && (writeRegM == rtE))
            forwardBE = 2'b10;
         else if ((rtE != '0) && regWriteW && (writeRegW == rtE))
            forwardBE = 2'b01;

         forwardAD = EB && (rsD != '0) && regWriteM && (writeRegM == rsD);
         forwardBD = EB && (rtD != '0) && regWriteM && (writeRegM == rtD);
      end
   end

   // A start request while already busy is ignored and does not reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_state <= MD_IDLE;
         md_cnt   <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (md_state)
            MD_IDLE: begin
               if (mdStartE) begin
                  md_state <= MD_BUSY;
                  md_cnt   <= MD_RELOAD;
                  busy_q   <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 8'd0) begin
                  md_state <= MD_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  md_cnt   <= md_cnt - 8'd1;
               end
            end
            MD_DONE: begin
               done_q <= 1'b0;
               if (mdStartE) begin
                  md_state <= MD_BUSY;
                  md_cnt   <= MD_RELOAD;
                  busy_q   <= 1'b1;
               end else begin
                  md_state <= MD_IDLE;
               end
            end
            default: begin
               md_state <= MD_IDLE;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (stallD && (stallCount != '1))
            stallCount <= stallCount + 1'b1;
         if ((flushD | flushE) && (flushCount != '1))
            flushCount <= flushCount + 1'b1;
      end
   end

endmodule
`default_nettype wire
